scan_chain_driver: RTL and testbench

- Host-side master for the processor scan chain (the `scan_enable` / `scan_in` / `scan_out` chain threaded through the control unit and its neighbouring registers).
- Takes bytes from a host valid/ready stream and serialises them into the chain.
- Captures the bits leaving the chain and returns them as bytes on a second valid/ready stream.
- Gates `processor_enable` off for the whole operation, so architectural state is read and written atomically.

---
 rtl/qtcore_scan_pkg.sv | 26 ++
 rtl/scan_chain_driver.sv | 105 ++++++++++
 tb/tb_scan_chain_driver.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qtcore_scan_pkg.sv
// Shared definitions for the scan-chain host driver: FSM encoding, byte width
// and a constant-foldable clog2 for deriving counter widths.
package qtcore_scan_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [4:0] {
        StIdle  = 5'b00001,
        StLoad  = 5'b00010,
        StShift = 5'b00100,
        StEmit  = 5'b01000,
        StDone  = 5'b10000
    } scan_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_chain_driver.sv
// Host-side scan-chain master: serialises host bytes into the chain LSB first while
// capturing the bits leaving it, and holds the core stopped for the whole pass.
module scan_chain_driver
    import qtcore_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 run_req,
    output logic                 processor_enable,
    output logic                 busy,
    output logic                 done,
    input  logic [ByteW-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ByteW-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 scan_enable,
    output logic                 chain_scan_in,
    input  logic                 chain_scan_out
);

    localparam int unsigned CNT_W = clog2(CHAIN_LEN + 1);

    scan_state_e      state_q, state_d;
    logic [ByteW-1:0] shreg_q, shreg_d;
    logic [3:0]       n_q, n_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            n_q         <= '0;
            bit_cnt_q   <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            n_q         <= n_d;
            bit_cnt_q   <= bit_cnt_d;
            bits_left_q <= bits_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        n_d         = n_q;
        bit_cnt_d   = bit_cnt_q;
        bits_left_d = bits_left_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    bits_left_d = CNT_W'(CHAIN_LEN);
                end
            end
            StLoad: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    n_d       = (32'(bits_left_q) < ByteW) ? 4'(bits_left_q) : 4'(ByteW);
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // Capture the chain's outgoing bit at the top as ours leaves at the bottom.
                shreg_d     = {chain_scan_out, shreg_q[ByteW-1:1]};
                bit_cnt_d   = bit_cnt_q + 3'd1;
                bits_left_d = bits_left_q - CNT_W'(1);
                if (bit_cnt_q == 3'(n_q - 4'd1)) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    state_d = (bits_left_q == '0) ? StDone : StLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign in_ready         = (state_q == StLoad);
    assign out_valid        = (state_q == StEmit);
    assign scan_enable      = (state_q == StShift);
    assign chain_scan_in    = scan_enable & shreg_q[0];
    assign processor_enable = run_req & ~busy;

    // A partial last byte sits in the top n bits; shift it down so the unused bits read 0.
    assign out_data = out_valid ? (shreg_q >> (4'(ByteW) - n_q)) : '0;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: 24-bit chain driven from a pass table with a byte
// scoreboard, plus a 12-bit instance for the partial final byte.
module tb_scan_chain_driver;

    typedef struct {
        logic [23:0] pre;
        logic        preload;
        logic [23:0] din;
        logic        run;
        int          bp;
        int          stall;
        logic [23:0] exp_out;
        logic [23:0] exp_post;
        int          exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       run_req = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       processor_enable, busy, done, in_ready, out_valid;
    logic       scan_enable, chain_scan_in, chain_scan_out;
    logic [7:0] out_data;

    logic       b_start = 1'b0;
    logic [7:0] b_in_data = 8'h00;
    logic       b_in_valid = 1'b0;
    logic       b_processor_enable, b_busy, b_done, b_in_ready, b_out_valid;
    logic       b_scan_enable, b_chain_scan_in, b_chain_scan_out;
    logic [7:0] b_out_data;

    logic [23:0] chain = '0;
    logic [23:0] pre_val = '0;
    logic        pre_req = 1'b0;
    logic [11:0] b_chain = '0;
    logic [11:0] b_pre_val = '0;
    logic        b_pre_req = 1'b0;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    logic       feed_en = 1'b1;
    logic       in_hs = 1'b0;
    logic       out_hs = 1'b0;
    logic [7:0] out_hs_data = 8'h00;
    int         tests = 0;
    int         fails = 0;
    int         se_cnt = 0;
    int         done_cnt = 0;
    int         out_cnt = 0;
    vec_t       vecs[4];

    always #5 clk = ~clk;

    scan_chain_driver #(.CHAIN_LEN(24)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .run_req          (run_req),
        .processor_enable (processor_enable),
        .busy             (busy),
        .done             (done),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .scan_enable      (scan_enable),
        .chain_scan_in    (chain_scan_in),
        .chain_scan_out   (chain_scan_out)
    );

    scan_chain_driver #(.CHAIN_LEN(12)) dut12 (
        .clk              (clk),
        .rst              (rst),
        .start            (b_start),
        .run_req          (1'b0),
        .processor_enable (b_processor_enable),
        .busy             (b_busy),
        .done             (b_done),
        .in_data          (b_in_data),
        .in_valid         (b_in_valid),
        .in_ready         (b_in_ready),
        .out_data         (b_out_data),
        .out_valid        (b_out_valid),
        .out_ready        (1'b1),
        .scan_enable      (b_scan_enable),
        .chain_scan_in    (b_chain_scan_in),
        .chain_scan_out   (b_chain_scan_out)
    );

    // Chain models: position 0 is the scan_out end.
    assign chain_scan_out   = chain[0];
    assign b_chain_scan_out = b_chain[0];

    always @(posedge clk) begin
        if (pre_req) chain <= pre_val;
        else if (scan_enable) chain <= {chain_scan_in, chain[23:1]};
        if (b_pre_req) b_chain <= b_pre_val;
        else if (b_scan_enable) b_chain <= {b_chain_scan_in, b_chain[11:1]};
        in_hs       <= in_valid & in_ready;
        out_hs      <= out_valid & out_ready;
        out_hs_data <= out_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Input stream driver.
    initial begin
        forever begin
            @(negedge clk);
            if (in_hs && in_q.size() > 0) void'(in_q.pop_front());
            in_valid = feed_en && (in_q.size() > 0);
            in_data  = (in_q.size() > 0) ? in_q[0] : 8'h00;
        end
    end

    // Output scoreboard and activity counters.
    initial begin
        forever begin
            @(negedge clk);
            if (out_hs) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_extra: got %0h, expected no byte", out_hs_data);
                end else begin
                    check("out_byte", 32'(out_hs_data), 32'(exp_q.pop_front()));
                end
            end
            if (scan_enable) se_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic run_pass(input vec_t v);
        int         cyc;
        int         bp_seen;
        logic       got, pe_bad, stall_bad, busy_bad;
        logic [7:0] snap;
        logic [23:0] chain_snap;
        if (v.preload) begin
            @(negedge clk);
            pre_val = v.pre;
            pre_req = 1'b1;
            @(negedge clk);
            pre_req = 1'b0;
        end
        @(negedge clk);
        se_cnt   = 0;
        done_cnt = 0;
        out_cnt  = 0;
        feed_en  = (v.stall == 0);
        out_ready = (v.bp == 0);
        for (int b = 0; b < 3; b++) begin
            in_q.push_back(v.din[8*b +: 8]);
            exp_q.push_back(v.exp_out[8*b +: 8]);
        end
        @(negedge clk);
        start      = 1'b1;
        run_req    = v.run;
        chain_snap = chain;
        snap       = 8'h00;
        cyc = 0; bp_seen = 0;
        got = 1'b0; pe_bad = 1'b0; stall_bad = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            // A start while busy must be dropped, not queued.
            if (v.run && cyc == 5) start = 1'b1;
            if (v.run && cyc == 6) start = 1'b0;
            if (done) got = 1'b1;
            if (v.run && processor_enable) pe_bad = 1'b1;
            if (v.stall != 0 && cyc <= 10) begin
                if (scan_enable || !in_ready || chain !== chain_snap) stall_bad = 1'b1;
                if (cyc == 10) feed_en = 1'b1;
            end
            if (v.bp != 0 && !out_ready) begin
                if (bp_seen == 0) begin
                    if (out_valid) begin
                        snap    = out_data;
                        bp_seen = 1;
                    end
                end else begin
                    check("bp_out_valid", 32'(out_valid), 1);
                    check("bp_out_data", 32'(out_data), 32'(snap));
                    check("bp_scan_enable", 32'(scan_enable), 0);
                    check("bp_in_ready", 32'(in_ready), 0);
                    bp_seen++;
                    if (bp_seen == 6) out_ready = 1'b1;
                end
            end
        end
        check("pass_done", 32'(got), 1);
        if (v.exp_lat != 0) check("pass_latency", cyc, v.exp_lat);
        @(negedge clk);
        check("busy_after", 32'(busy), 0);
        check("pe_after", 32'(processor_enable), 32'(v.run));
        check("out_count", out_cnt, 3);
        check("sb_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("se_cycles", se_cnt, 24);
        check("chain_post", 32'(chain), 32'(v.exp_post));
        if (v.run) check("pe_during", 32'(pe_bad), 0);
        if (v.stall != 0) check("stall_quiet", 32'(stall_bad), 0);
        if (v.run) begin
            busy_bad = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (busy) busy_bad = 1'b1;
            end
            check("no_queued_start", 32'(busy_bad), 0);
        end
        run_req   = 1'b0;
        out_ready = 1'b1;
        feed_en   = 1'b1;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic reset_mid_shift();
        logic [23:0] exp_chain;
        logic [7:0]  din;
        int          sc;
        int          cyc;
        @(negedge clk);
        pre_val = 24'h0F0F0F;
        pre_req = 1'b1;
        @(negedge clk);
        pre_req = 1'b0;
        in_q.push_back(8'h77);
        in_q.push_back(8'h88);
        in_q.push_back(8'h99);
        @(negedge clk);
        start = 1'b1;
        din = 8'h77;
        exp_chain = 24'h0F0F0F;
        for (int j = 0; j < 3; j++) exp_chain = {din[j], exp_chain[23:1]};
        sc = 0;
        cyc = 0;
        while (sc < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (scan_enable) sc++;
        end
        check("rst_reached_shift", sc, 4);
        rst = 1'b1;
        #1;
        check("rst_scan_enable", 32'(scan_enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_chain_scan_in", 32'(chain_scan_in), 0);
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_chain", 32'(chain), 32'(exp_chain));
        rst = 1'b0;
    endtask

    task automatic run_dut12();
        logic [7:0] din[2];
        logic [7:0] exp12[2];
        int         idx, k, cyc, sc;
        logic       got;
        din[0] = 8'hFF;
        din[1] = 8'h05;
        exp12[0] = 8'hBC;
        exp12[1] = 8'h0A;
        @(negedge clk);
        b_pre_val = 12'hABC;
        b_pre_req = 1'b1;
        @(negedge clk);
        b_pre_req = 1'b0;
        b_start = 1'b1;
        idx = 0; k = 0; cyc = 0; sc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            b_start = 1'b0;
            if (b_done) got = 1'b1;
            if (b_scan_enable) sc++;
            if (b_out_valid) begin
                if (k < 2) check("c12_out", 32'(b_out_data), 32'(exp12[k]));
                k++;
            end
            if (b_in_ready && !b_in_valid && idx < 2) begin
                b_in_valid = 1'b1;
                b_in_data  = din[idx];
                idx++;
            end else begin
                b_in_valid = 1'b0;
            end
        end
        check("c12_done", 32'(got), 1);
        check("c12_latency", cyc, 17);
        check("c12_out_count", k, 2);
        check("c12_se_cycles", sc, 12);
        @(negedge clk);
        check("c12_chain_post", 32'(b_chain), 32'h5FF);
        check("c12_busy_after", 32'(b_busy), 0);
    endtask

    initial begin
        vecs[0] = '{pre: 24'hA5C3F0, preload: 1'b1, din: 24'h332211, run: 1'b0, bp: 0,
                    stall: 0, exp_out: 24'hA5C3F0, exp_post: 24'h332211, exp_lat: 31};
        vecs[1] = '{pre: 24'h000000, preload: 1'b0, din: 24'h5A0F96, run: 1'b0, bp: 1,
                    stall: 0, exp_out: 24'h332211, exp_post: 24'h5A0F96, exp_lat: 0};
        vecs[2] = '{pre: 24'h000000, preload: 1'b0, din: 24'hC0FFEE, run: 1'b0, bp: 0,
                    stall: 1, exp_out: 24'h5A0F96, exp_post: 24'hC0FFEE, exp_lat: 0};
        vecs[3] = '{pre: 24'h13579B, preload: 1'b1, din: 24'h2468AC, run: 1'b1, bp: 0,
                    stall: 0, exp_out: 24'h13579B, exp_post: 24'h2468AC, exp_lat: 31};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_scan_enable", 32'(scan_enable), 0);
        check("reset_chain_scan_in", 32'(chain_scan_in), 0);
        check("reset_out_data", 32'(out_data), 0);
        run_req = 1'b1;
        #1;
        check("reset_pe_follows_1", 32'(processor_enable), 1);
        run_req = 1'b0;
        #1;
        check("reset_pe_follows_0", 32'(processor_enable), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (i == 3) reset_mid_shift();
            run_pass(vecs[i]);
        end
        run_dut12();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
